// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages, with flush, sticky halt and a
// saturating back-pressure counter. in_ready is derived from registered state only.
//
// state   | meaning
// --------+--------------------------------------------
// S_EMPTY | no beat held (occupancy 0)
// S_ONE   | main holds a beat, skid empty (occupancy 1)
// S_FULL  | main and skid both hold beats (occupancy 2)
module pipe_skid_reg #(
  parameter int DATA_W   = 128,
  parameter int HALT_BIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic              halted,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_halted;
  logic [CNT_W-1:0]  r_stall;

  logic w_accept;
  logic w_drain;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  // The skid slot is occupied exactly when the FSM is FULL.
  assign in_ready  = (r_state != S_FULL) & ~r_halted & ~RST;
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_main;
  assign halted    = r_halted;
  assign occupancy = r_state;
  assign stall_cnt = r_stall;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = S_ONE;
          w_load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && !w_drain) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_accept && w_drain) begin
          w_load_main_in = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_drain) begin
          w_state_nxt      = S_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush drops everything held and any beat offered this cycle.
    if (flush) begin
      w_state_nxt      = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= in_data;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= in_data;
    end
  end

  // A drain during a flush cycle still delivers, so it may still set halted.
  always_ff @(posedge CLK) begin
    if (RST)                            r_halted <= 1'b0;
    else if (w_drain && r_main[HALT_BIT]) r_halted <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      r_stall <= '0;
    else if (out_valid && !out_ready && (r_stall != {CNT_W{1'b1}}))
      r_stall <= r_stall + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based model.
module tb_pipe_skid_reg;
  localparam int DW = 16;
  localparam int HB = 12;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          flush = 1'b0;
  logic          halted;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  always #5 CLK = ~CLK;

  pipe_skid_reg #(.DATA_W(DW), .HALT_BIT(HB), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .halted(halted), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: FIFO of held beats (head = what the stage presents), plus flags.
  logic [DW-1:0] q[$];
  bit m_halted = 1'b0;
  int m_stall  = 0;
  bit m_zero   = 1'b0;
  bit m_init   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit m_rdy;
    m_rdy = !RST && (q.size() < 2) && !m_halted;
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(m_rdy));
    chk("halted",    32'(halted),    32'(m_halted));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (q.size() > 0)  chk("out_data", 32'(out_data), 32'(q[0]));
    else if (m_zero)   chk("out_data_rst", 32'(out_data), 32'h0);
  endtask

  task automatic model_update();
    bit            rdy;
    bit            acc;
    logic [DW-1:0] b;
    if (RST) begin
      q.delete();
      m_halted = 1'b0;
      m_stall  = 0;
      m_zero   = 1'b1;
      m_init   = 1'b1;
    end else if (m_init) begin
      rdy = (q.size() < 2) && !m_halted;
      acc = in_valid && rdy;
      if (q.size() > 0 && !out_ready && m_stall < SAT) m_stall++;
      if (q.size() > 0 && out_ready) begin
        b = q.pop_front();
        if (b[HB]) m_halted = 1'b1;
      end
      if (flush) q.delete();
      else if (acc) begin
        q.push_back(in_data);
        m_zero = 1'b0;
      end
    end
  endtask

  // Drive one cycle's inputs at the negedge, check, advance the model, wait a cycle.
  task automatic tick(input bit rst, input bit iv, input logic [DW-1:0] d,
                      input bit ordy, input bit fl);
    RST = rst; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    if (m_init) compare();
    model_update();
    @(negedge CLK);
  endtask

  initial begin
    logic [DW-1:0] d;
    bit r, iv, ordy, fl;
    @(negedge CLK);

    // Streaming
    tick(1, 0, '0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick(0, 1, DW'(k), 1, 0);
      chk("stream_data", 32'(out_data), 32'(k));
      chk("stream_occ", 32'(occupancy), 32'd1);
    end
    tick(0, 0, '0, 1, 0);
    chk("stream_empty", 32'(occupancy), 32'd0);

    // Back-pressure
    tick(1, 0, '0, 0, 0);
    tick(0, 1, 16'hA, 0, 0);
    chk("bp_occ1", 32'(occupancy), 32'd1);
    tick(0, 1, 16'hB, 0, 0);
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold", 32'(out_data), 32'hA);
    repeat (4) tick(0, 0, '0, 0, 0);
    chk("bp_stall5", 32'(stall_cnt), 32'd5);
    chk("bp_hold2", 32'(out_data), 32'hA);
    tick(0, 0, '0, 1, 0);
    chk("bp_second", 32'(out_data), 32'hB);
    chk("bp_occ_after", 32'(occupancy), 32'd1);
    tick(0, 0, '0, 1, 0);
    chk("bp_drained", 32'(occupancy), 32'd0);
    chk("bp_stall_kept", 32'(stall_cnt), 32'd5);

    // Flush while full with an offered beat
    tick(1, 0, '0, 0, 0);
    tick(0, 1, 16'hA, 0, 0);
    tick(0, 1, 16'hB, 0, 0);
    tick(0, 1, 16'hC, 1, 1);
    chk("fl_occ", 32'(occupancy), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_stall", 32'(stall_cnt), 32'd1);
    repeat (3) begin
      tick(0, 0, '0, 1, 0);
      chk("fl_no_c", 32'(out_valid), 32'd0);
    end

    // Halt
    tick(1, 0, '0, 0, 0);
    tick(0, 1, 16'h1005, 0, 0);
    tick(0, 1, 16'hD, 0, 0);
    tick(0, 1, 16'hE, 1, 0);
    chk("halt_set", 32'(halted), 32'd1);
    chk("halt_occ", 32'(occupancy), 32'd1);
    chk("halt_d", 32'(out_data), 32'hD);
    chk("halt_block", 32'(in_ready), 32'd0);
    tick(0, 1, 16'hE, 1, 0);
    chk("halt_drained", 32'(occupancy), 32'd0);
    chk("halt_sticky", 32'(halted), 32'd1);
    tick(0, 1, 16'hF, 1, 0);
    chk("halt_ignored", 32'(occupancy), 32'd0);

    // Reset while full
    tick(1, 0, '0, 0, 0);
    tick(0, 1, 16'hA, 0, 0);
    tick(0, 1, 16'hB, 0, 0);
    tick(1, 1, 16'h7, 1, 1);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    RST = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);

    // Reset while halted with a beat held
    tick(0, 1, 16'h1001, 0, 0);
    tick(0, 1, 16'h2, 0, 0);
    tick(0, 0, '0, 1, 0);
    chk("rh_halted", 32'(halted), 32'd1);
    tick(1, 0, '0, 0, 0);
    chk("rh_halted_clr", 32'(halted), 32'd0);
    chk("rh_occ", 32'(occupancy), 32'd0);

    // Saturation
    tick(1, 0, '0, 0, 0);
    tick(0, 1, 16'h3, 0, 0);
    repeat (20) tick(0, 0, '0, 0, 0);
    chk("sat_stall", 32'(stall_cnt), 32'(SAT));

    // Random
    tick(1, 0, '0, 0, 0);
    repeat (3000) begin
      d = DW'($urandom);
      if ($urandom_range(39) != 0) d[HB] = 1'b0;
      r    = ($urandom_range(199) == 0) || (m_halted && $urandom_range(19) == 0);
      iv   = ($urandom_range(9) < 7);
      ordy = ($urandom_range(9) < 6);
      fl   = ($urandom_range(29) == 0);
      tick(r, iv, d, ordy, fl);
    end
    tick(0, 0, '0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128: width of the stage payload (decode-to-execute bundle).
REQ-002 SHALL have parameter HALT_BIT, default 0: payload bit index carrying the halt flag; legal range 0..DATA_W-1.
REQ-003 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-004 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: upstream beat offered.
REQ-007 SHALL have port in_ready, output, 1: stage can accept a beat.
REQ-008 SHALL have port in_data, input, DATA_W: upstream payload.
REQ-009 SHALL have port out_valid, output, 1: downstream beat offered.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts.
REQ-011 SHALL have port out_data, output, DATA_W: downstream payload.
REQ-012 SHALL have port flush, input, 1: discard all held beats (branch/jump mispredict).
REQ-013 SHALL have port halted, output, 1: a halt-flagged beat has left the stage.
REQ-014 SHALL have port occupancy, output, 2: number of held beats, 0..2.
REQ-015 SHALL have port stall_cnt, output, CNT_W: count of back-pressured cycles.

Function
REQ-016 SHALL hold beats in two registers: main (drives out_data) and skid; out_valid SHALL equal the main-valid flag.
REQ-017 SHALL define accept = in_valid & in_ready and drain = out_valid & out_ready, both evaluated in the same cycle.
REQ-018 SHALL drive in_ready = !skid_valid & !halted & !RST, from registered state only; no combinational path from out_ready or in_valid to in_ready.
REQ-019 SHALL implement states EMPTY (occ 0), ONE (occ 1), and FULL (occ 2) with the following transitions.
REQ-020 EMPTY: accept -> ONE, main<=in_data; otherwise stay in EMPTY.
REQ-021 ONE: accept & !drain -> FULL, skid<=in_data; accept & drain -> ONE, main<=in_data; drain only -> EMPTY; neither -> ONE, unchanged.
REQ-022 FULL: in_ready=0; drain -> ONE, main<=skid; otherwise stay in FULL, unchanged.
REQ-023 SHALL preserve beat order, with no loss or duplication.
REQ-024 SHALL have latency 1: a beat accepted at edge N into EMPTY appears with out_valid=1 after edge N.
REQ-025 SHALL sustain 1 beat/cycle while out_ready is held 1.
REQ-026 flush SHALL force occupancy to 0 at the next edge; a beat offered in the flush cycle SHALL be discarded; a drain in the flush cycle SHALL still count as delivered.
REQ-027 flush SHALL NOT clear halted or stall_cnt.
REQ-028 When a drain occurs with out_data[HALT_BIT]=1, halted SHALL be 1 from the next edge.
REQ-029 halted SHALL be sticky until RST and SHALL block new accepts; beats already held SHALL still drain normally.
REQ-030 stall_cnt SHALL increment by 1 each cycle with out_valid & !out_ready.
REQ-031 stall_cnt SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-032 out_data SHALL remain stable while out_valid & !out_ready.

Reset
REQ-033 While RST=1 at an edge, the following SHALL hold after that edge: occupancy=0, out_valid=0, out_data=0, skid=0, halted=0, stall_cnt=0.
REQ-034 in_ready SHALL be 0 while RST=1 and SHALL be 1 in the first cycle after RST deasserts.
REQ-035 RST SHALL take priority over flush, accept and drain.
REQ-036 Reset mid-operation SHALL discard held beats, and no drain SHALL be counted for that cycle.

Verification
REQ-037 Streaming: out_ready=1, send 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive cycles, 1 cycle latency, occupancy never 2.
REQ-038 Back-pressure: out_ready=0, send 0xA, 0xB -> occupancy=2, in_ready=0, out_data=0xA held; stall 5 cycles -> stall_cnt=5; release -> 0xA then 0xB, occupancy returns to 0.
REQ-039 Flush while FULL with in_valid=1 (0xC) -> next cycle occupancy=0, out_valid=0, 0xC never appears; stall_cnt unchanged.
REQ-040 Halt: drain beat with HALT_BIT=1 followed by 0xD held in skid -> halted=1, 0xD still drains, further in_valid ignored (in_ready=0).
REQ-041 Saturation (CNT_W=4): 20 stalled cycles -> stall_cnt=15.
REQ-042 Reset while FULL and halted -> all outputs 0; in_ready=1 the cycle after RST drops.
